spi_cmd_arbiter: RTL and testbench

SPI_CMD_ARBITER -- requirements
Module: spi_cmd_arbiter

---
 rtl/spi_arb_pkg.sv | 41 ++++
 rtl/spi_rr_arbiter.sv | 36 +++
 rtl/spi_cmd_arbiter.sv | 129 ++++++++++++
 tb/tb_spi_cmd_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_arb_pkg.sv
// Shared definitions for the SPI command arbiter: mode encodings,
// command field positions, FSM state enum and the beat-count helper.
package spi_arb_pkg;

  localparam int CMD_W_DEF = 15;

  // Command layout: {data[14:7], addr[6:2], mode[1:0]}
  localparam int DATA_MSB = 14;
  localparam int DATA_LSB = 7;
  localparam int ADDR_MSB = 6;
  localparam int ADDR_LSB = 2;
  localparam int MODE_MSB = 1;
  localparam int MODE_LSB = 0;

  typedef enum logic [1:0] {
    MODE_RD    = 2'b00,
    MODE_RDINC = 2'b01,
    MODE_WR    = 2'b10,
    MODE_RSV   = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10
  } state_e;

  // Number of read beats the master returns for a given mode; RD-increment
  // with a zero length still moves one beat.
  function automatic logic [8:0] expected_beats(input mode_e mode, input logic [7:0] n);
    logic [8:0] beats;
    case (mode)
      MODE_WR:    beats = 9'd0;
      MODE_RD:    beats = 9'd1;
      MODE_RDINC: beats = (n == 8'd0) ? 9'd1 : {1'b0, n};
      default:    beats = 9'd0;
    endcase
    return beats;
  endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// Two-way round-robin grant. The pointer only moves when the grant is
// actually taken (advance), so a stalled arbiter keeps its fairness order.
module spi_rr_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  // 1 when requester 1 has priority on a tie (requester 0 won last)
  logic prio1_r;

  // One-hot grant from the current requests and the priority pointer
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = prio1_r ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  // Hand priority to the requester that did not win this grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio1_r <= 1'b0;
    end else if (advance) begin
      prio1_r <= grant[0];
    end else begin
      prio1_r <= prio1_r;
    end
  end

endmodule

// File: rtl/spi_cmd_arbiter.sv
// Arbitrates two command requesters onto one SPI master, forwards read
// beats back to the owning requester and aborts stuck transactions.
module spi_cmd_arbiter
  import spi_arb_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1024,
  parameter int CMD_W       = CMD_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  input  logic [CMD_W-1:0] req_cmd0,
  input  logic [CMD_W-1:0] req_cmd1,
  input  logic [1:0]       req_cs,
  output logic [1:0]       req_ready,
  output logic [1:0]       rsp_valid,
  output logic [7:0]       rsp_data,
  output logic [CMD_W-1:0] m_cmd,
  output logic             m_cmd_valid,
  output logic             m_cs_sel,
  input  logic             m_ready,
  input  logic [7:0]       m_rdata,
  input  logic             m_rdata_valid,
  output logic             err_mode,
  output logic             err_timeout
);

  localparam int            TW      = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

  state_e           state_r;
  logic             owner_r;
  logic [8:0]       exp_r;
  logic [8:0]       beat_r;
  logic [TW-1:0]    wait_cnt_r;

  logic [1:0]       grant_s;
  logic             advance_s;
  logic             win_s;
  logic [CMD_W-1:0] win_cmd_s;
  logic             win_cs_s;
  mode_e            win_mode_s;

  spi_rr_arbiter u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .advance (advance_s),
    .grant   (grant_s)
  );

  // Select the winning command; accept pulse is combinational in IDLE
  always_comb begin
    advance_s  = (state_r == ST_IDLE) && (req_valid != 2'b00);
    req_ready  = advance_s ? grant_s : 2'b00;
    win_s      = grant_s[1];
    win_cmd_s  = win_s ? req_cmd1 : req_cmd0;
    win_cs_s   = win_s ? req_cs[1] : req_cs[0];
    win_mode_s = mode_e'(win_cmd_s[MODE_MSB:MODE_LSB]);
  end

  // Transaction FSM with registered master, response and error outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      owner_r     <= 1'b0;
      exp_r       <= 9'd0;
      beat_r      <= 9'd0;
      wait_cnt_r  <= '0;
      m_cmd       <= '0;
      m_cmd_valid <= 1'b0;
      m_cs_sel    <= 1'b1;
      rsp_valid   <= 2'b00;
      rsp_data    <= 8'd0;
      err_mode    <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      rsp_valid   <= 2'b00;
      err_mode    <= 1'b0;
      err_timeout <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (advance_s) begin
            owner_r <= win_s;
            if (win_mode_s == MODE_RSV) begin
              // Reserved mode is swallowed here; the master never sees it
              err_mode <= 1'b1;
            end else begin
              m_cmd       <= win_cmd_s;
              m_cs_sel    <= win_cs_s;
              exp_r       <= expected_beats(win_mode_s, win_cmd_s[DATA_MSB:DATA_LSB]);
              m_cmd_valid <= 1'b1;
              state_r     <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (m_ready) begin
            m_cmd_valid <= 1'b0;
            beat_r      <= 9'd0;
            wait_cnt_r  <= '0;
            state_r     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // Surplus beats are dropped once the expected count is reached
          if (m_rdata_valid && (beat_r < exp_r)) begin
            rsp_valid[owner_r] <= 1'b1;
            rsp_data           <= m_rdata;
            beat_r             <= beat_r + 9'd1;
          end
          if (m_ready && (beat_r == exp_r)) begin
            state_r <= ST_IDLE;
          end else if (wait_cnt_r == TO_LAST) begin
            err_timeout <= 1'b1;
            state_r     <= ST_IDLE;
          end else begin
            wait_cnt_r <= wait_cnt_r + TW'(1);
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          m_cmd_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cmd_arbiter.sv
// Directed bench for spi_cmd_arbiter with hand-computed expectations.
module tb_spi_cmd_arbiter;

  localparam int T = 20;

  localparam logic [14:0] CMD_WR0   = 15'b000100010000110;
  localparam logic [14:0] CMD_WR1   = 15'h2A5A;
  localparam logic [14:0] CMD_RDINC = 15'b000001010000101;
  localparam logic [14:0] CMD_RD    = 15'b101010100001000;
  localparam logic [14:0] CMD_RSV   = 15'b000000000000111;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [14:0] req_cmd0, req_cmd1;
  logic [1:0]  req_cs;
  logic [1:0]  req_ready, rsp_valid;
  logic [7:0]  rsp_data;
  logic [14:0] m_cmd;
  logic        m_cmd_valid, m_cs_sel, m_ready;
  logic [7:0]  m_rdata;
  logic        m_rdata_valid, err_mode, err_timeout;

  int checks = 0;
  int failures = 0;

  int mcv_cnt = 0, rsp0_cnt = 0, rsp1_cnt = 0, errm_cnt = 0, errt_cnt = 0;
  logic grants[$];

  spi_cmd_arbiter #(.TIMEOUT_CYC(T), .CMD_W(15)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_cmd0(req_cmd0),
    .req_cmd1(req_cmd1), .req_cs(req_cs), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .m_cmd(m_cmd),
    .m_cmd_valid(m_cmd_valid), .m_cs_sel(m_cs_sel), .m_ready(m_ready),
    .m_rdata(m_rdata), .m_rdata_valid(m_rdata_valid),
    .err_mode(err_mode), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // Event tallies sampled mid-cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (m_cmd_valid)  mcv_cnt++;
      if (rsp_valid[0]) rsp0_cnt++;
      if (rsp_valid[1]) rsp1_cnt++;
      if (err_mode)     errm_cnt++;
      if (err_timeout)  errt_cnt++;
      if (req_ready != 2'b00) grants.push_back(req_ready[1]);
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    check_val({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check_val({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
    check_val({tag, "_m_cmd"}, 32'(m_cmd), 32'd0);
    check_val({tag, "_m_cs_sel"}, 32'(m_cs_sel), 32'd1);
    check_val({tag, "_m_cmd_valid"}, 32'(m_cmd_valid), 32'd0);
    check_val({tag, "_err"}, {30'd0, err_mode, err_timeout}, 32'd0);
  endtask

  task automatic run_wr(input int idx, input logic [14:0] cmd, input logic [1:0] cs, input string tag);
    cyc();
    m_ready = 1'b1;
    req_cs  = cs;
    if (idx == 0) begin req_cmd0 = cmd; req_valid = 2'b01; end
    else begin req_cmd1 = cmd; req_valid = 2'b10; end
    smp();
    check_val({tag, "_ready"}, 32'(req_ready), (idx == 0) ? 32'd1 : 32'd2);
    cyc();
    req_valid = 2'b00;
    smp();
    check_val({tag, "_mcv"}, 32'(m_cmd_valid), 32'd1);
    check_val({tag, "_mcmd"}, 32'(m_cmd), 32'(cmd));
    repeat (3) cyc();
  endtask

  int b_mcv, b_r0, b_r1, b_em, b_et, found;

  initial begin
    rst = 1'b1; req_valid = 2'b00; req_cmd0 = '0; req_cmd1 = '0; req_cs = 2'b00;
    m_ready = 1'b0; m_rdata = 8'd0; m_rdata_valid = 1'b0;
    repeat (3) smp();
    check_reset_outputs("rst");
    cyc();
    rst = 1'b0;

    // Single WR from requester 0
    b_mcv = mcv_cnt; b_r0 = rsp0_cnt; b_r1 = rsp1_cnt;
    run_wr(0, CMD_WR0, 2'b01, "wr0");
    check_val("wr0_cs", 32'(m_cs_sel), 32'd1);
    check_val("wr0_mcv_cycles", 32'(mcv_cnt - b_mcv), 32'd1);
    check_val("wr0_no_rsp", 32'(rsp0_cnt + rsp1_cnt - b_r0 - b_r1), 32'd0);
    cyc(); req_valid = 2'b10; req_cmd1 = CMD_WR1; smp();
    check_val("wr0_back_idle", 32'(req_ready), 32'd2);
    cyc(); req_valid = 2'b00; repeat (3) cyc();

    // Round robin from reset, both requesters streaming WRs
    rst = 1'b1; cyc(); rst = 1'b0;
    grants.delete();
    b_mcv = mcv_cnt;
    req_cmd0 = CMD_WR0; req_cmd1 = CMD_WR1; req_cs = 2'b01; m_ready = 1'b1;
    req_valid = 2'b11;
    for (int i = 0; i < 60; i++) begin
      smp();
      if (grants.size() >= 6) break;
    end
    cyc(); req_valid = 2'b00; repeat (4) cyc();
    check_val("rr_count", 32'(grants.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < grants.size()) check_val($sformatf("rr_grant%0d", i), 32'(grants[i]), 32'(i % 2));
    end
    check_val("rr_mcv_cycles", 32'(mcv_cnt - b_mcv), 32'd6);

    // RD-increment, 5 beats to requester 1
    b_r0 = rsp0_cnt; b_r1 = rsp1_cnt;
    cyc(); req_valid = 2'b10; req_cmd1 = CMD_RDINC; req_cs = 2'b00; m_ready = 1'b1;
    smp(); check_val("inc_ready", 32'(req_ready), 32'd2);
    cyc(); req_valid = 2'b00;
    smp();
    check_val("inc_mcv", 32'(m_cmd_valid), 32'd1);
    check_val("inc_mcmd", 32'(m_cmd), 32'(CMD_RDINC));
    check_val("inc_cs", 32'(m_cs_sel), 32'd0);
    for (int k = 1; k <= 5; k++) begin
      cyc(); m_ready = 1'b0; m_rdata_valid = 1'b1; m_rdata = 8'(k * 17);
      smp(); check_val($sformatf("inc_nolat%0d", k), 32'(rsp_valid), 32'd0);
      cyc(); m_rdata_valid = 1'b0;
      smp();
      check_val($sformatf("inc_rv%0d", k), 32'(rsp_valid), 32'd2);
      check_val($sformatf("inc_rd%0d", k), 32'(rsp_data), 32'(k * 17));
    end
    cyc(); m_ready = 1'b1; cyc(); cyc();
    check_val("inc_rsp1_total", 32'(rsp1_cnt - b_r1), 32'd5);
    check_val("inc_rsp0_none", 32'(rsp0_cnt - b_r0), 32'd0);

    // RD with a surplus beat
    b_r0 = rsp0_cnt;
    cyc(); req_valid = 2'b01; req_cmd0 = CMD_RD; req_cs = 2'b01;
    smp(); check_val("rd_ready", 32'(req_ready), 32'd1);
    cyc(); req_valid = 2'b00;
    cyc(); m_ready = 1'b0; m_rdata_valid = 1'b1; m_rdata = 8'hA1;
    cyc(); m_rdata = 8'hB2;
    smp(); check_val("rd_rv", 32'(rsp_valid), 32'd1); check_val("rd_data", 32'(rsp_data), 32'hA1);
    cyc(); m_rdata_valid = 1'b0;
    smp(); check_val("rd_drop_rv", 32'(rsp_valid), 32'd0); check_val("rd_drop_data", 32'(rsp_data), 32'hA1);
    cyc(); m_ready = 1'b1; cyc(); cyc();
    check_val("rd_rsp0_total", 32'(rsp0_cnt - b_r0), 32'd1);

    // Timeout in WAIT
    b_r0 = rsp0_cnt; b_r1 = rsp1_cnt; b_et = errt_cnt;
    cyc(); req_valid = 2'b10; req_cmd1 = CMD_RD; m_ready = 1'b1;
    cyc(); req_valid = 2'b00;
    cyc(); m_ready = 1'b0;
    found = 0;
    for (int i = 1; i <= T + 4; i++) begin
      smp();
      if (err_timeout && found == 0) found = i;
    end
    check_val("to_cycle", 32'(found), 32'(T + 1));
    check_val("to_pulses", 32'(errt_cnt - b_et), 32'd1);
    check_val("to_no_rsp", 32'(rsp0_cnt + rsp1_cnt - b_r0 - b_r1), 32'd0);
    run_wr(0, CMD_WR1, 2'b01, "to_next");

    // Reserved mode
    b_mcv = mcv_cnt; b_em = errm_cnt;
    cyc(); req_valid = 2'b01; req_cmd0 = CMD_RSV;
    smp(); check_val("rsv_ready", 32'(req_ready), 32'd1);
    cyc(); req_valid = 2'b00;
    smp();
    check_val("rsv_err", 32'(err_mode), 32'd1);
    check_val("rsv_mcv", 32'(m_cmd_valid), 32'd0);
    check_val("rsv_mcmd_hold", 32'(m_cmd), 32'(CMD_WR1));
    cyc(); smp();
    check_val("rsv_err_pulse", 32'(errm_cnt - b_em), 32'd1);
    check_val("rsv_no_fwd", 32'(mcv_cnt - b_mcv), 32'd0);

    // Reset in the middle of WAIT
    cyc(); req_valid = 2'b10; req_cmd1 = CMD_RDINC; req_cs = 2'b00; m_ready = 1'b1;
    cyc(); req_valid = 2'b00;
    cyc(); m_ready = 1'b0; m_rdata_valid = 1'b1; m_rdata = 8'h77;
    cyc(); m_rdata_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    cyc(); rst = 1'b0;
    b_r0 = rsp0_cnt; b_r1 = rsp1_cnt; b_em = errm_cnt; b_et = errt_cnt; b_mcv = mcv_cnt;
    m_ready = 1'b1; m_rdata_valid = 1'b1; m_rdata = 8'h99;
    repeat (4) cyc();
    m_rdata_valid = 1'b0;
    repeat (T + 4) cyc();
    check_val("midrst_no_rsp", 32'(rsp0_cnt + rsp1_cnt - b_r0 - b_r1), 32'd0);
    check_val("midrst_no_err", 32'(errm_cnt + errt_cnt - b_em - b_et), 32'd0);
    check_val("midrst_no_mcv", 32'(mcv_cnt - b_mcv), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
